// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the MIPS HI/LO registers.
// Define MULDIV_DIV_EN to include the restoring divider (DIV/DIVU); otherwise those functs are illegal.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
`ifdef MULDIV_DIV_EN
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
`endif

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 busy_q, busy_d, done_q, done_d, illegal_q, illegal_d;

    logic                 signed_op, a_neg, b_neg, accept;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   prod;

    assign signed_op = ~funct[0];
    assign a_neg     = signed_op & op_a[WIDTH-1];
    assign b_neg     = signed_op & op_b[WIDTH-1];
    assign a_mag     = a_neg ? -op_a : op_a;
    assign b_mag     = b_neg ? -op_b : op_b;
    assign accept    = start && (state_q == IDLE || state_q == DONE);
    // acc = {partial product, remaining multiplier bits}
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign prod      = neg_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
    logic                 is_div_q, is_div_d, rem_neg_q, rem_neg_d, div_ge;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH-1:0]     rem_diff;

    // acc = {partial remainder, dividend bits still to shift in / quotient bits}
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge   = rem_sh >= {1'b0, mcand_q};
    assign rem_diff = rem_sh[WIDTH-1:0] - mcand_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        neg_d     = neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
`ifdef MULDIV_DIV_EN
        is_div_d  = is_div_q;
        rem_neg_d = rem_neg_q;
`endif
        case (state_q)
            ITER: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
                if (is_div_q)
                    acc_d = div_ge ? {rem_diff, acc_q[WIDTH-2:0], 1'b1}
                                   : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
`endif
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1))
                    state_d = FIX;
            end
            FIX: begin
                hi_d = prod[2*WIDTH-1:WIDTH];
                lo_d = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    lo_d = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end
`endif
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                if (accept) begin
                    case (funct)
                        F_MULT, F_MULTU: begin
                            state_d = ITER;
                            busy_d  = 1'b1;
                            cnt_d   = '0;
                            acc_d   = {{WIDTH{1'b0}}, b_mag};
                            mcand_d = a_mag;
                            neg_d   = a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
                            is_div_d = 1'b0;
`endif
                        end
`ifdef MULDIV_DIV_EN
                        F_DIV, F_DIVU: begin
                            state_d   = ITER;
                            busy_d    = 1'b1;
                            cnt_d     = '0;
                            acc_d     = {{WIDTH{1'b0}}, a_mag};
                            mcand_d   = b_mag;
                            // a zero divisor must yield an all-ones quotient regardless of sign
                            neg_d     = (a_neg ^ b_neg) & (op_b != '0);
                            rem_neg_d = a_neg;
                            is_div_d  = 1'b1;
                        end
`endif
                        F_MTHI: begin
                            hi_d    = op_a;
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                        F_MTLO: begin
                            lo_d    = op_a;
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                        F_MFHI, F_MFLO: begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            neg_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q  <= 1'b0;
            rem_neg_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            neg_q     <= neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
`ifdef MULDIV_DIV_EN
            is_div_q  <= is_div_d;
            rem_neg_q <= rem_neg_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign illegal = illegal_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH = 32): directed and random operations against a
// 64-bit arithmetic reference model; follows MULDIV_DIV_EN to decide whether DIV/DIVU are legal.
module tb_muldiv_unit;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  funct = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, done, illegal;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .funct(funct),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .illegal(illegal), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge where the DUT is IDLE or in its DONE cycle; returns at the negedge
    // of the done cycle (or one cycle after the illegal pulse).
    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] p, qv, rv;
        longint      q, r;
        bit          ill, lng;
        int          cyc, bcnt;
        ill = 0;
        lng = 0;
        case (f)
            F_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                hi_m = p[63:32]; lo_m = p[31:0]; lng = 1;
            end
            F_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                hi_m = p[63:32]; lo_m = p[31:0]; lng = 1;
            end
            F_DIV, F_DIVU: begin
`ifdef MULDIV_DIV_EN
                lng = 1;
                if (b == 32'h0) begin
                    lo_m = 32'hFFFF_FFFF; hi_m = a;
                end else if (f == F_DIV) begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    qv = q; rv = r;
                    lo_m = qv[31:0]; hi_m = rv[31:0];
                end else begin
                    lo_m = a / b; hi_m = a % b;
                end
`else
                ill = 1;
`endif
            end
            F_MTHI: hi_m = a;
            F_MTLO: lo_m = a;
            F_MFHI, F_MFLO: ;
            default: ill = 1;
        endcase

        start = 1'b1; funct = f; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0; funct = 6'($urandom); op_a = $urandom; op_b = $urandom;
        cyc = 1;
        bcnt = 0;
        while (done !== 1'b1 && illegal !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) bcnt++;
            if (cyc == 5) begin start = 1'b1; funct = F_MTHI; end
            if (cyc == 6) start = 1'b0;
            @(negedge clk);
            cyc++;
        end

        if (ill) begin
            check({name, " illegal"}, {63'b0, illegal}, 64'd1);
            check({name, " lat"}, 64'(cyc), 64'd1);
            check({name, " busy_cnt"}, 64'(bcnt), 64'd0);
            check({name, " hi"}, {32'b0, hi}, {32'b0, hi_m});
            check({name, " lo"}, {32'b0, lo}, {32'b0, lo_m});
            @(negedge clk);
            check({name, " illegal_pulse"}, {63'b0, illegal}, 64'd0);
            check({name, " no_busy"}, {63'b0, busy}, 64'd0);
        end else begin
            check({name, " done"}, {63'b0, done}, 64'd1);
            check({name, " lat"}, 64'(cyc), lng ? 64'd34 : 64'd1);
            check({name, " busy_cnt"}, 64'(bcnt), lng ? 64'd33 : 64'd0);
            check({name, " hi"}, {32'b0, hi}, {32'b0, hi_m});
            check({name, " lo"}, {32'b0, lo}, {32'b0, lo_m});
        end
    endtask

    initial begin
        logic [5:0] ftab [10];
        int         dcnt;
        ftab = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, F_MFHI, F_MFLO,
                 6'b100000, 6'b000000};

        repeat (2) @(negedge clk);
        check("rst hi", {32'b0, hi}, 64'd0);
        check("rst lo", {32'b0, lo}, 64'd0);
        check("rst busy", {63'b0, busy}, 64'd0);
        check("rst done", {63'b0, done}, 64'd0);
        check("rst illegal", {63'b0, illegal}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max hi_const", {32'b0, hi}, 64'h0000_0000_FFFF_FFFE);
        run_op("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'd5);
        check("mult_neg lo_const", {32'b0, lo}, 64'h0000_0000_FFFF_FFF1);
        run_op("mult_b2b", F_MULT, 32'd7, 32'd6);
        check("mult_b2b lo_const", {32'b0, lo}, 64'h0000_0000_0000_002A);
        run_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_zero", F_DIVU, 32'd10, 32'd0);
        run_op("div_zero", F_DIV, 32'hFFFF_FFF0, 32'd0);
        run_op("mthi", F_MTHI, 32'h1234_5678, 32'd0);
        run_op("mtlo", F_MTLO, 32'hCAFE_F00D, 32'd0);
        run_op("mfhi", F_MFHI, 32'hDEAD_BEEF, 32'd0);
        run_op("bad_funct", 6'b100000, 32'h1111_1111, 32'h2222_2222);
        @(negedge clk);
        check("idle done", {63'b0, done}, 64'd0);

        for (int i = 0; i < 40; i++) begin
            run_op($sformatf("rnd%0d", i), ftab[$urandom_range(0, 9)], pick_operand(),
                   pick_operand());
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end

        run_op("pre_rst", F_MTHI, 32'hA5A5_A5A5, 32'd0);
        start = 1'b1; funct = F_MULT; op_a = 32'd123; op_b = 32'd456;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst hi", {32'b0, hi}, 64'd0);
        check("mid_rst lo", {32'b0, lo}, 64'd0);
        check("mid_rst busy", {63'b0, busy}, 64'd0);
        check("mid_rst done", {63'b0, done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        hi_m = '0;
        lo_m = '0;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        check("post_rst no_done", 64'(dcnt), 64'd0);
        run_op("post_rst_mtlo", F_MTLO, 32'h0BAD_CAFE, 32'd0);
        run_op("post_rst_mult", F_MULT, 32'h8000_0000, 32'h8000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
